hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 17 +
 rtl/mdu_busy_tracker.sv | 59 +++++
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 tb/tb_hazard_scoreboard.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard scoreboard and its MDU busy tracker.
// Optional stall-cycle counter is enabled elsewhere by HAZARD_PERF_CNT_EN.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  localparam int MDU_CNT_W = 8;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_BUSY = 2'b01,
    MDU_DONE = 2'b10
  } mduState_t;

endpackage

// File: rtl/mdu_busy_tracker.sv
// Tracks an in-flight multi-cycle mul/div: MDU_LAT busy cycles, then a one-cycle done.
// state | meaning: IDLE | no op in flight; BUSY | counting down MDU_LAT cycles; DONE | result ready this cycle
module mdu_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      mdu_startE,
  output logic      mdu_busy,
  output logic      mdu_done,
  output mduState_t state
);

  localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_LAT - 1);
  localparam logic [MDU_CNT_W-1:0] CNT_ONE  = MDU_CNT_W'(1);

  mduState_t            stateNext;
  logic [MDU_CNT_W-1:0] cnt;
  logic [MDU_CNT_W-1:0] cntNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Starts arriving while BUSY or DONE are dropped; the counter is untouched.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      MDU_IDLE: begin
        if (mdu_startE) begin
          stateNext = MDU_BUSY;
          cntNext   = CNT_LOAD;
        end
      end
      MDU_BUSY: begin
        if (cnt == '0) begin
          stateNext = MDU_DONE;
        end else begin
          cntNext = cnt - CNT_ONE;
        end
      end
      MDU_DONE: stateNext = MDU_IDLE;
      default:  stateNext = MDU_IDLE;
    endcase
  end

  assign mdu_busy = (state == MDU_BUSY);
  assign mdu_done = (state == MDU_DONE);

endmodule

// File: rtl/hazard_scoreboard.sv
// Five-stage pipeline hazard unit: E/D forwarding selects, load-use/branch/MDU stalls.
// Define HAZARD_PERF_CNT_EN to add the saturating stall_cycles counter output.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int MDU_LAT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rsD,
  input  logic [ADDR_W-1:0] rtD,
  input  logic [ADDR_W-1:0] rsE,
  input  logic [ADDR_W-1:0] rtE,
  input  logic [ADDR_W-1:0] wregE,
  input  logic [ADDR_W-1:0] wregM,
  input  logic [ADDR_W-1:0] wregW,
  input  logic              weE,
  input  logic              weM,
  input  logic              weW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic              branchD,
  input  logic              mdu_useD,
  input  logic              mdu_startE,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              flushE,
  output logic              mdu_busy,
  output logic              mdu_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  mduState_t mduState;
  logic      loadUseStall;
  logic      branchStall;
  logic      mduStall;
  logic      stallAny;

  // Register 0 is hardwired to zero, so it never matches a producer.
  function automatic logic regHit(input logic [ADDR_W-1:0] src,
                                  input logic [ADDR_W-1:0] dst,
                                  input logic              en);
    return en && (dst != '0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwdSelE(input logic [ADDR_W-1:0] src);
    if (regHit(src, wregM, weM)) begin
      return FWD_M;
    end else if (regHit(src, wregW, weW)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  mdu_busy_tracker #(
    .MDU_LAT (MDU_LAT)
  ) uMduTracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .mdu_startE (mdu_startE),
    .mdu_busy   (mdu_busy),
    .mdu_done   (mdu_done),
    .state      (mduState)
  );

  assign forwardAE = fwdSelE(rsE);
  assign forwardBE = fwdSelE(rtE);

  // A load in M has no data yet, so the D-stage comparator cannot take it.
  assign forwardAD = regHit(rsD, wregM, weM) && !memtoregM;
  assign forwardBD = regHit(rtD, wregM, weM) && !memtoregM;

  assign loadUseStall = memtoregE &&
                        (regHit(rsD, wregE, weE) || regHit(rtD, wregE, weE));

  assign branchStall = branchD &&
                       (regHit(rsD, wregE, weE) || regHit(rtD, wregE, weE) ||
                        regHit(rsD, wregM, memtoregM) || regHit(rtD, wregM, memtoregM));

  assign mduStall = mdu_useD && (mduState != MDU_IDLE);

  assign stallAny = loadUseStall || branchStall || mduStall;
  assign stallF   = stallAny;
  assign stallD   = stallAny;
  assign flushE   = stallAny;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stallD && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: spec-level model plus directed literal vectors.
module tb_hazard_scoreboard;

  localparam int AW  = 5;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] rsD, rtD, rsE, rtE, wregE, wregM, wregW;
  logic weE, weM, weW, memtoregE, memtoregM, branchD, mdu_useD, mdu_startE;
  logic forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic stallF, stallD, flushE, mdu_busy, mdu_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;
  int cyc = 0;
  int mStart = -1;

  always #5 clk = ~clk;

  hazard_scoreboard #(.ADDR_W(AW), .MDU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .wregE(wregE), .wregM(wregM), .wregW(wregW),
    .weE(weE), .weM(weM), .weW(weW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .mdu_useD(mdu_useD), .mdu_startE(mdu_startE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an op started at cycle s is busy in cycles s+1..s+LAT and done in s+LAT+1.
  function automatic bit mBusyAt(int c);
    return (mStart >= 0) && (c >= mStart + 1) && (c <= mStart + LAT);
  endfunction

  function automatic bit mDoneAt(int c);
    return (mStart >= 0) && (c == mStart + LAT + 1);
  endfunction

  function automatic logic [1:0] expFwdE(logic [AW-1:0] s);
    if (s == 0) return 2'b00;
    if (weM && s == wregM) return 2'b01;
    if (weW && s == wregW) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit expFwdD(logic [AW-1:0] s);
    return (s != 0) && weM && !memtoregM && (s == wregM);
  endfunction

  function automatic bit expStall();
    bit lu, br, md;
    lu = memtoregE && weE && (wregE != 0) && (wregE == rsD || wregE == rtD);
    br = branchD && ((weE && wregE != 0 && (wregE == rsD || wregE == rtD)) ||
                     (memtoregM && wregM != 0 && (wregM == rsD || wregM == rtD)));
    md = mdu_useD && (mBusyAt(cyc) || mDoneAt(cyc));
    return lu || br || md;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mStart = -1;
    end else begin
      if (mdu_startE && !mBusyAt(cyc) && !mDoneAt(cyc)) mStart = cyc;
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      chk("m_fwdAE", 32'(forwardAE), 32'(expFwdE(rsE)));
      chk("m_fwdBE", 32'(forwardBE), 32'(expFwdE(rtE)));
      chk("m_fwdAD", 32'(forwardAD), 32'(expFwdD(rsD)));
      chk("m_fwdBD", 32'(forwardBD), 32'(expFwdD(rtD)));
      chk("m_stallF", 32'(stallF), 32'(expStall()));
      chk("m_stallD", 32'(stallD), 32'(expStall()));
      chk("m_flushE", 32'(flushE), 32'(expStall()));
      chk("m_busy", 32'(mdu_busy), 32'(mBusyAt(cyc)));
      chk("m_done", 32'(mdu_done), 32'(mDoneAt(cyc)));
    end
  end

  task automatic setIdle();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    wregE = '0; wregM = '0; wregW = '0;
    weE = 0; weM = 0; weW = 0; memtoregE = 0; memtoregM = 0;
    branchD = 0; mdu_useD = 0; mdu_startE = 0;
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setLoadUse();
    memtoregE = 1; weE = 1; wregE = 5'd3; rtD = 5'd3;
  endtask

  task automatic dirVec(input string name,
                        input logic [AW-1:0] vRsD, vRtD, vRsE, vWregE, vWregM, vWregW,
                        input logic vWeE, vWeM, vWeW, vMtrE, vMtrM, vBr,
                        input logic [1:0] eAE, input logic eAD, input logic eStall);
    setIdle();
    rsD = vRsD; rtD = vRtD; rsE = vRsE; wregE = vWregE; wregM = vWregM; wregW = vWregW;
    weE = vWeE; weM = vWeM; weW = vWeW; memtoregE = vMtrE; memtoregM = vMtrM; branchD = vBr;
    #1;
    chk({name, "_fwdAE"}, 32'(forwardAE), 32'(eAE));
    chk({name, "_fwdAD"}, 32'(forwardAD), 32'(eAD));
    chk({name, "_stallF"}, 32'(stallF), 32'(eStall));
    chk({name, "_stallD"}, 32'(stallD), 32'(eStall));
    chk({name, "_flushE"}, 32'(flushE), 32'(eStall));
    nextCyc();
  endtask

  initial begin
    setIdle();
    rst_n = 1'b0;
    checkEn = 1'b1;
    #2;
    chk("rst_busy", 32'(mdu_busy), 32'd0);
    chk("rst_done", 32'(mdu_done), 32'd0);
    nextCyc();
    nextCyc();
    rst_n = 1'b1;
    nextCyc();

    //           name     rsD rtD rsE wE wM wW  weE weM weW mE mM br  AE     AD stall
    dirVec("fwdM",    0,  0,  5,  0, 5, 5,  0,  1,  1,  0, 0, 0, 2'b01, 0, 0);
    dirVec("fwdW",    0,  0,  5,  0, 5, 5,  0,  0,  1,  0, 0, 0, 2'b10, 0, 0);
    dirVec("fwdWonly",0,  0,  6,  0, 2, 6,  0,  1,  1,  0, 0, 0, 2'b10, 0, 0);
    dirVec("ldUse",   0,  3,  0,  3, 0, 0,  1,  0,  0,  1, 0, 0, 2'b00, 0, 1);
    dirVec("ldUseR0", 0,  0,  0,  0, 0, 0,  1,  0,  0,  1, 0, 0, 2'b00, 0, 0);
    dirVec("brLoadM", 7,  0,  0,  0, 7, 0,  0,  1,  0,  0, 1, 1, 2'b00, 0, 1);
    dirVec("brAluM",  7,  0,  0,  0, 7, 0,  0,  1,  0,  0, 0, 1, 2'b00, 1, 0);
    dirVec("brAluE",  2,  4,  0,  4, 0, 0,  1,  0,  0,  0, 0, 1, 2'b00, 0, 1);
    dirVec("zeroAddr",0,  0,  0,  0, 0, 0,  1,  1,  1,  1, 1, 1, 2'b00, 0, 0);

    // MDU sequence with starts during BUSY and DONE that must be ignored.
    for (int k = 0; k < 8; k++) begin
      setIdle();
      mdu_startE = (k == 0 || k == 2 || k == 5);
      mdu_useD = (k == 3 || k == 6);
      if (k == 3) setLoadUse();
      #1;
      chk($sformatf("mdu_busy_c%0d", k), 32'(mdu_busy), 32'(k >= 1 && k <= 4));
      chk($sformatf("mdu_done_c%0d", k), 32'(mdu_done), 32'(k == 5));
      chk($sformatf("mdu_stallD_c%0d", k), 32'(stallD), 32'(k == 3));
      nextCyc();
    end

    // Abort mid-BUSY via asynchronous reset.
    setIdle();
    mdu_startE = 1;
    nextCyc();
    mdu_startE = 0;
    nextCyc();
    #1;
    chk("abort_busy_pre", 32'(mdu_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(mdu_busy), 32'd0);
    chk("abort_done", 32'(mdu_done), 32'd0);
    nextCyc();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      nextCyc();
      chk("abort_noDone", 32'(mdu_done), 32'd0);
    end

    for (int k = 0; k < 80; k++) begin
      rsD = AW'($urandom_range(0, 3)); rtD = AW'($urandom_range(0, 3));
      rsE = AW'($urandom_range(0, 3)); rtE = AW'($urandom_range(0, 3));
      wregE = AW'($urandom_range(0, 3)); wregM = AW'($urandom_range(0, 3));
      wregW = AW'($urandom_range(0, 3));
      weE = 1'($urandom); weM = 1'($urandom); weW = 1'($urandom);
      memtoregE = 1'($urandom); memtoregM = 1'($urandom); branchD = 1'($urandom);
      mdu_useD = 1'($urandom);
      mdu_startE = ($urandom_range(0, 5) == 0);
      nextCyc();
    end

`ifdef HAZARD_PERF_CNT_EN
    setIdle();
    rst_n = 1'b0;
    nextCyc();
    rst_n = 1'b1;
    nextCyc();
    chk("perf_rst", stall_cycles, 32'd0);
    for (int k = 0; k < 10; k++) begin
      setIdle();
      setLoadUse();
      nextCyc();
    end
    setIdle();
    #1;
    chk("perf_ten", stall_cycles, 32'd10);
    force dut.stall_cycles = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cycles;
    for (int k = 0; k < 5; k++) begin
      setIdle();
      setLoadUse();
      nextCyc();
    end
    setIdle();
    #1;
    chk("perf_sat", stall_cycles, 32'hFFFF_FFFF);
`endif

    setIdle();
    nextCyc();
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
